btb_update_queue: RTL and testbench

Buffers resolved taken-branch updates from the two retire slots and drains them into the two write ports of `branch_target_buffer`. Retire writes up to two updates per cycle. The BTB can be stalled, and two updates that map to the same BTB index cannot be written on both ports in one cycle. This block absorbs that mismatch, keeps updates in program order, and merges same-index updates so the newest target wins.

---
 rtl/btb_update_queue_if.sv | 26 ++
 rtl/btb_update_queue.sv | 154 +++++++++++++++
 tb/tb_btb_update_queue.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/btb_update_queue_if.sv
// Retire-side and BTB-side signal bundle for btb_update_queue.
// slave is the queue itself; master is whoever drives retire updates and BTB stall.
interface btb_update_queue_if #(
  parameter int XLEN        = 32,
  parameter int QUEUE_DEPTH = 8
);
  logic [1:0]                     in_valid;
  logic [1:0][XLEN-1:0]           in_pc;
  logic [1:0][XLEN-1:0]           in_target;
  logic                           in_ready;
  logic                           btb_stall;
  logic [1:0]                     wr_en;
  logic [1:0][XLEN-1:0]           wr_addr;
  logic [1:0][XLEN-1:0]           wr_target_pc;
  logic [$clog2(QUEUE_DEPTH):0]   count;

  modport master (
    output in_valid, in_pc, in_target, btb_stall,
    input  in_ready, wr_en, wr_addr, wr_target_pc, count
  );

  modport slave (
    input  in_valid, in_pc, in_target, btb_stall,
    output in_ready, wr_en, wr_addr, wr_target_pc, count
  );
endinterface

// File: rtl/btb_update_queue.sv
// Circular FIFO between the two retire slots and the two BTB write ports.
// Keeps program order, folds same-index neighbours so the newest target wins,
// and never puts two writes to the same index on the BTB in one cycle.
module btb_update_queue #(
  parameter int QUEUE_DEPTH = 8,
  parameter int XLEN        = 32,
  parameter int BTB_SIZE    = 32,
  parameter int IDX_BITS    = $clog2(BTB_SIZE)
) (
  input logic                clock,
  input logic                reset,
  btb_update_queue_if.slave  bus
);
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam logic [PW:0] CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0] CNT_TWO  = (PW+1)'(2);
  localparam logic [PW:0] READY_MAX = (PW+1)'(QUEUE_DEPTH - 2);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] tgt;
  } entry_t;

  entry_t                 mem_q [QUEUE_DEPTH];
  logic [PW-1:0]          head_q, head_d, tail_q, tail_d;
  logic [PW:0]            count_q, count_d;
  logic [1:0]             wr_en_q, wr_en_d;
  logic [1:0][XLEN-1:0]   wr_addr_q, wr_addr_d;
  logic [1:0][XLEN-1:0]   wr_tgt_q, wr_tgt_d;

  // enqueue side
  logic                   in_ready;
  logic                   wa_en, wb_en;
  entry_t                 wa, wb;
  logic [PW:0]            pushed;
  logic [PW-1:0]          tail_p1;
  logic                   pair_same;

  // drain side
  logic [PW:0]            popped;
  logic [PW-1:0]          head_p1;
  entry_t                 hd0, hd1;
  logic                   head_same;

  // Ready looks only at registered count; a same-cycle pop is not credited.
  assign in_ready  = (count_q <= READY_MAX);
  assign tail_p1   = tail_q + 1'b1;
  assign head_p1   = head_q + 1'b1;
  assign pair_same = (bus.in_pc[0][IDX_BITS+1:2] == bus.in_pc[1][IDX_BITS+1:2]);
  assign hd0       = mem_q[head_q];
  assign hd1       = mem_q[head_p1];
  assign head_same = (hd0.pc[IDX_BITS+1:2] == hd1.pc[IDX_BITS+1:2]);

  // Compact valid slots onto tail in age order; a same-index pair keeps only slot 1.
  always_comb begin
    wa_en  = 1'b0;
    wb_en  = 1'b0;
    wa     = '{pc: bus.in_pc[0], tgt: bus.in_target[0]};
    wb     = '{pc: bus.in_pc[1], tgt: bus.in_target[1]};
    pushed = '0;
    if (in_ready) begin
      case (bus.in_valid)
        2'b01: begin
          wa_en  = 1'b1;
          pushed = CNT_ONE;
        end
        2'b10: begin
          wa_en  = 1'b1;
          wa     = '{pc: bus.in_pc[1], tgt: bus.in_target[1]};
          pushed = CNT_ONE;
        end
        2'b11: begin
          if (pair_same) begin
            wa_en  = 1'b1;
            wa     = '{pc: bus.in_pc[1], tgt: bus.in_target[1]};
            pushed = CNT_ONE;
          end else begin
            wa_en  = 1'b1;
            wb_en  = 1'b1;
            pushed = CNT_TWO;
          end
        end
        default: ;
      endcase
    end
  end

  // Pick the next BTB write: single pop, dual pop, or coalesce head into head+1.
  always_comb begin
    popped    = '0;
    wr_en_d   = 2'b00;
    wr_addr_d = wr_addr_q;
    wr_tgt_d  = wr_tgt_q;
    if (!bus.btb_stall && (count_q != '0)) begin
      if (count_q == CNT_ONE) begin
        popped       = CNT_ONE;
        wr_en_d      = 2'b01;
        wr_addr_d[0] = hd0.pc;
        wr_tgt_d[0]  = hd0.tgt;
      end else if (head_same) begin
        // older entry is superseded; only the newer target reaches the BTB
        popped       = CNT_TWO;
        wr_en_d      = 2'b01;
        wr_addr_d[0] = hd1.pc;
        wr_tgt_d[0]  = hd1.tgt;
      end else begin
        popped       = CNT_TWO;
        wr_en_d      = 2'b11;
        wr_addr_d[0] = hd0.pc;
        wr_tgt_d[0]  = hd0.tgt;
        wr_addr_d[1] = hd1.pc;
        wr_tgt_d[1]  = hd1.tgt;
      end
    end
  end

  // Pointer and count next-state; power-of-two depth makes wrap free.
  always_comb begin
    head_d  = head_q + popped[PW-1:0];
    tail_d  = tail_q + pushed[PW-1:0];
    count_d = count_q + pushed - popped;
  end

  // Control state and registered BTB write port.
  always_ff @(posedge clock) begin
    if (reset) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      wr_en_q   <= 2'b00;
      wr_addr_q <= '0;
      wr_tgt_q  <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_tgt_q  <= wr_tgt_d;
    end
  end

  // Entry storage; contents are meaningless outside [head, head+count) so no reset.
  always_ff @(posedge clock) begin
    if (wa_en) mem_q[tail_q]  <= wa;
    if (wb_en) mem_q[tail_p1] <= wb;
  end

  assign bus.in_ready     = in_ready;
  assign bus.wr_en        = wr_en_q;
  assign bus.wr_addr      = wr_addr_q;
  assign bus.wr_target_pc = wr_tgt_q;
  assign bus.count        = count_q;
endmodule

// File: tb/tb_btb_update_queue.sv
// Bench for btb_update_queue: table of single-transaction vectors plus
// hand-written multi-cycle sequences; BTB writes are checked against a scoreboard.
module tb_btb_update_queue;
  localparam int XLEN = 32;
  localparam int QD   = 8;

  typedef struct {
    logic [1:0]  en;
    logic [31:0] a0, a1, t0, t1;
  } wr_t;

  typedef struct {
    logic [1:0]  v;
    logic [31:0] p0, p1, t0, t1;
    int          exp_cnt;
    wr_t         exp_wr;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;
  wr_t  sb[$];
  vec_t vecs[5];

  always #5 clock = ~clock;

  btb_update_queue_if #(.XLEN(XLEN), .QUEUE_DEPTH(QD)) bus();

  btb_update_queue #(.QUEUE_DEPTH(QD), .XLEN(XLEN), .BTB_SIZE(32), .IDX_BITS(5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1,
                       input logic [31:0] t0, input logic [31:0] t1);
    bus.in_valid     = v;
    bus.in_pc[0]     = p0;
    bus.in_pc[1]     = p1;
    bus.in_target[0] = t0;
    bus.in_target[1] = t1;
  endtask

  task automatic expect_wr(input logic [1:0] en, input logic [31:0] a0, input logic [31:0] a1,
                           input logic [31:0] t0, input logic [31:0] t1);
    wr_t w;
    w.en = en; w.a0 = a0; w.a1 = a1; w.t0 = t0; w.t1 = t1;
    sb.push_back(w);
  endtask

  // Every BTB write must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (!reset && bus.wr_en != 2'b00) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_write: got wr_en %b addr0 %0h, want no write", bus.wr_en, bus.wr_addr[0]);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("sb_wr_en", 32'(bus.wr_en), 32'(e.en));
        chk("sb_addr0", bus.wr_addr[0], e.a0);
        chk("sb_tgt0", bus.wr_target_pc[0], e.t0);
        if (e.en[1]) begin
          chk("sb_addr1", bus.wr_addr[1], e.a1);
          chk("sb_tgt1", bus.wr_target_pc[1], e.t1);
        end
      end
    end
  end

  initial begin
    // single-transaction vectors: {valid, pcs, targets, count after capture, expected write}
    vecs[0] = '{2'b11, 32'd78,   32'd231,  32'd12,    32'd13,    2, '{2'b11, 32'd78,   32'd231,  32'd12,    32'd13}};
    vecs[1] = '{2'b11, 32'h40,   32'hC0,   32'h100,   32'h200,   1, '{2'b01, 32'hC0,   32'h0,    32'h200,   32'h0}};
    vecs[2] = '{2'b10, 32'h0,    32'h300,  32'h0,     32'h55,    1, '{2'b01, 32'h300,  32'h0,    32'h55,    32'h0}};
    vecs[3] = '{2'b01, 32'h1004, 32'h0,    32'h77,    32'h0,     1, '{2'b01, 32'h1004, 32'h0,    32'h77,    32'h0}};
    vecs[4] = '{2'b11, 32'h10,   32'h14,   32'hAAAA,  32'hBBBB,  2, '{2'b11, 32'h10,   32'h14,   32'hAAAA,  32'hBBBB}};

    bus.btb_stall = 1'b0;
    drive(2'b00, 0, 0, 0, 0);

    // reset values
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_wr_addr0", bus.wr_addr[0], 32'd0);
    chk("rst_wr_addr1", bus.wr_addr[1], 32'd0);

    // table-driven single transactions: capture, drain 1 cycle later, idle
    for (int i = 0; i < 5; i++) begin
      drive(vecs[i].v, vecs[i].p0, vecs[i].p1, vecs[i].t0, vecs[i].t1);
      expect_wr(vecs[i].exp_wr.en, vecs[i].exp_wr.a0, vecs[i].exp_wr.a1,
                vecs[i].exp_wr.t0, vecs[i].exp_wr.t1);
      tick();
      drive(2'b00, 0, 0, 0, 0);
      chk($sformatf("v%0d_count_cap", i), 32'(bus.count), 32'(vecs[i].exp_cnt));
      tick();
      chk($sformatf("v%0d_wr_en", i), 32'(bus.wr_en), 32'(vecs[i].exp_wr.en));
      chk($sformatf("v%0d_count_drained", i), 32'(bus.count), 32'd0);
      tick();
      chk($sformatf("v%0d_wr_en_idle", i), 32'(bus.wr_en), 32'd0);
    end

    // backpressure: fill under stall, overflow pair ignored, then drain 4 dual writes
    bus.btb_stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(2'b11, 32'(8*k), 32'(8*k+4), 32'(32'h1000 + 8*k), 32'(32'h1000 + 8*k + 4));
      expect_wr(2'b11, 32'(8*k), 32'(8*k+4), 32'(32'h1000 + 8*k), 32'(32'h1000 + 8*k + 4));
      tick();
    end
    drive(2'b00, 0, 0, 0, 0);
    chk("bp_count_full", 32'(bus.count), 32'd8);
    chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    drive(2'b11, 32'h80, 32'h84, 32'h9990, 32'h9994);
    tick();
    drive(2'b00, 0, 0, 0, 0);
    chk("bp_count_ignored", 32'(bus.count), 32'd8);
    chk("bp_wr_en_stalled", 32'(bus.wr_en), 32'd0);
    bus.btb_stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("bp_wr_en_%0d", k), 32'(bus.wr_en), 32'd3);
    end
    chk("bp_count_empty", 32'(bus.count), 32'd0);
    tick();
    chk("bp_wr_en_idle", 32'(bus.wr_en), 32'd0);

    // walk head to QUEUE_DEPTH-1: fresh reset, 7 entries in, 7 out
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.btb_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(2'b11, 32'(32'h200 + 8*k), 32'(32'h204 + 8*k), 32'(32'h50 + k), 32'(32'h60 + k));
      expect_wr(2'b11, 32'(32'h200 + 8*k), 32'(32'h204 + 8*k), 32'(32'h50 + k), 32'(32'h60 + k));
      tick();
    end
    drive(2'b01, 32'h218, 32'h0, 32'h70, 32'h0);
    expect_wr(2'b01, 32'h218, 32'h0, 32'h70, 32'h0);
    tick();
    drive(2'b00, 0, 0, 0, 0);
    chk("wrap_prefill_count", 32'(bus.count), 32'd7);
    bus.btb_stall = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("wrap_prefill_last_en", 32'(bus.wr_en), 32'd1);
    chk("wrap_prefill_empty", 32'(bus.count), 32'd0);
    tick();

    // cross-entry coalesce across the wrap point (entries at 7 and 0)
    bus.btb_stall = 1'b1;
    drive(2'b01, 32'h14, 32'h0, 32'hA, 32'h0);
    tick();
    drive(2'b01, 32'h94, 32'h0, 32'hB, 32'h0);
    tick();
    drive(2'b00, 0, 0, 0, 0);
    chk("coal_count_before", 32'(bus.count), 32'd2);
    expect_wr(2'b01, 32'h94, 32'h0, 32'hB, 32'h0);
    bus.btb_stall = 1'b0;
    tick();
    chk("coal_wr_en", 32'(bus.wr_en), 32'd1);
    chk("coal_wr_addr0", bus.wr_addr[0], 32'h94);
    chk("coal_wr_tgt0", bus.wr_target_pc[0], 32'hB);
    chk("coal_count_after", 32'(bus.count), 32'd0);
    tick();
    chk("coal_wr_en_idle", 32'(bus.wr_en), 32'd0);

    // reset mid-operation drops pending entries
    bus.btb_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(2'b11, 32'(32'h300 + 8*k), 32'(32'h304 + 8*k), 32'(32'hE0 + k), 32'(32'hF0 + k));
      tick();
    end
    drive(2'b00, 0, 0, 0, 0);
    chk("mid_count_before", 32'(bus.count), 32'd6);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.btb_stall = 1'b0;
    chk("mid_count_rst", 32'(bus.count), 32'd0);
    chk("mid_in_ready", 32'(bus.in_ready), 32'd1);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("mid_wr_en_%0d", k), 32'(bus.wr_en), 32'd0);
      chk($sformatf("mid_count_%0d", k), 32'(bus.count), 32'd0);
    end

    chk("sb_leftover", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
